// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word memory answering controller requests after WAIT wait states.
// Optional MemErr out-of-range flag is built when CPU_MEM_ERR_EN is defined.
module cpu_mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 192,
    parameter int WAIT   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemWData,
    output logic [DATA_W-1:0] MemRData,
    output logic              MemReady,
    output logic              MemBusy
`ifdef CPU_MEM_ERR_EN
    ,
    output logic              MemErr
`endif
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              acc_wr, acc_ok, enter_resp;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [IDX_W-1:0]  acc_idx;

    // From IDLE the access resolves off the live inputs so WAIT=0 can respond on the accepting edge.
    assign acc_wr    = (state_q == S_IDLE) ? MemWrite : wr_q;
    assign acc_addr  = (state_q == S_IDLE) ? MemAddr : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? MemWData : wdata_q;
    assign acc_ok    = {1'b0, acc_addr} < DEPTH_L;
    assign acc_idx   = acc_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (MemReq) begin
                state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                cnt_d   = WAIT_L;
                wr_d    = MemWrite;
                addr_d  = MemAddr;
                wdata_d = MemWData;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        if (enter_resp && !acc_wr) rdata_d = acc_ok ? mem[acc_idx] : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left unreset; out-of-range writes are dropped here.
    always_ff @(posedge Clk) begin
        if (!Reset && enter_resp && acc_wr && acc_ok) mem[acc_idx] <= acc_wdata;
    end

    assign MemRData = rdata_q;
    assign MemReady = (state_q == S_RESP);
    assign MemBusy  = (state_q != S_IDLE);
`ifdef CPU_MEM_ERR_EN
    assign MemErr   = (state_q == S_RESP) && !({1'b0, addr_q} < DEPTH_L);
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed bench for cpu_mem_responder at WAIT=2 and WAIT=0
// against a cycle-scheduled access model.
module tb_cpu_mem_responder;
    localparam int NI = 2;
`ifdef CPU_MEM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemReq = 1'b0;
    logic        MemWrite = 1'b0;
    logic [7:0]  MemAddr = '0;
    logic [15:0] MemWData = '0;
    logic [15:0] rd2, rd0;
    logic        rdy2, rdy0, bsy2, bsy0, err2, err0;
    logic [15:0] rd_w [NI];
    logic        rdy_w [NI], bsy_w [NI], err_w [NI];
    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(192), .WAIT(2)) u_w2 (
        .Clk(Clk), .Reset(Reset), .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRData(rd2), .MemReady(rdy2), .MemBusy(bsy2)
`ifdef CPU_MEM_ERR_EN
        , .MemErr(err2)
`endif
    );

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(192), .WAIT(0)) u_w0 (
        .Clk(Clk), .Reset(Reset), .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRData(rd0), .MemReady(rdy0), .MemBusy(bsy0)
`ifdef CPU_MEM_ERR_EN
        , .MemErr(err0)
`endif
    );

`ifndef CPU_MEM_ERR_EN
    assign err2 = 1'b0;
    assign err0 = 1'b0;
`endif
    assign rd_w[0] = rd2;
    assign rd_w[1] = rd0;
    assign rdy_w[0] = rdy2;
    assign rdy_w[1] = rdy0;
    assign bsy_w[0] = bsy2;
    assign bsy_w[1] = bsy0;
    assign err_w[0] = err2;
    assign err_w[1] = err0;

    function automatic int wt(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an access accepted at edge n responds at edge n+W, and the next one may start at n+W+2.
    int          n = 0;
    bit          armed = 1'b0;
    bit          have [NI];
    int          resp_at [NI];
    int          free_at [NI];
    bit          a_wr [NI];
    logic [7:0]  a_addr [NI];
    logic [15:0] a_data [NI];
    logic [15:0] mm [NI][256];
    bit          mk [NI][256];
    logic [15:0] e_rd [NI];
    bit          e_rdk [NI];
    bit          e_busy [NI], e_ready [NI], e_err [NI];

    initial forever begin
        @(posedge Clk);
        n++;
        for (int i = 0; i < NI; i++) begin
            if (Reset) begin
                have[i] = 1'b0;
                free_at[i] = n + 1;
                e_rd[i] = '0;
                e_rdk[i] = 1'b1;
                armed = 1'b1;
            end else begin
                if (n >= free_at[i] && MemReq) begin
                    have[i] = 1'b1;
                    a_wr[i] = MemWrite;
                    a_addr[i] = MemAddr;
                    a_data[i] = MemWData;
                    resp_at[i] = n + wt(i);
                    free_at[i] = n + wt(i) + 2;
                end
                if (have[i] && n == resp_at[i]) begin
                    if (a_addr[i] < 8'd192) begin
                        if (a_wr[i]) begin
                            mm[i][a_addr[i]] = a_data[i];
                            mk[i][a_addr[i]] = 1'b1;
                        end else begin
                            e_rd[i] = mm[i][a_addr[i]];
                            e_rdk[i] = mk[i][a_addr[i]];
                        end
                    end else if (!a_wr[i]) begin
                        e_rd[i] = '0;
                        e_rdk[i] = 1'b1;
                    end
                end
            end
            e_busy[i] = have[i] && n <= resp_at[i];
            e_ready[i] = have[i] && n == resp_at[i];
            e_err[i] = ERR_ON && e_ready[i] && a_addr[i] >= 8'd192;
        end
        @(negedge Clk);
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("busy[%0d]", i), bsy_w[i], e_busy[i]);
                chk($sformatf("ready[%0d]", i), rdy_w[i], e_ready[i]);
                chk($sformatf("err[%0d]", i), err_w[i], e_err[i]);
                if (e_rdk[i]) chk($sformatf("rdata[%0d]", i), rd_w[i], e_rd[i]);
            end
        end
    end

    // One request pulse; inputs are scrambled while busy. Returns WAIT=2 latency/data and WAIT=0 first-cycle view.
    task automatic access(input logic wr, input logic [7:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic b,
                          output logic er, output logic r0, output logic [15:0] rd0_o);
        @(negedge Clk);
        MemReq = 1'b1;
        MemWrite = wr;
        MemAddr = a;
        MemWData = d;
        @(negedge Clk);
        b = bsy_w[0];
        r0 = rdy_w[1];
        rd0_o = rd_w[1];
        MemReq = 1'b0;
        MemWrite = ~wr;
        MemAddr = ~a;
        MemWData = ~d;
        lat = 0;
        while (!rdy_w[0] && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        rd = rd_w[0];
        er = err_w[0];
        @(negedge Clk);
        chk("ready_single_pulse", rdy_w[0], 1'b0);
    endtask

    initial begin
        int lat, cnt, last;
        logic [15:0] rd, r0d, exp;
        logic b, er, r0;
        repeat (3) @(negedge Clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_busy", bsy_w[i], 1'b0);
            chk("reset_ready", rdy_w[i], 1'b0);
            chk("reset_rdata", rd_w[i], 16'h0000);
        end
        Reset = 1'b0;

        access(1'b1, 8'h10, 16'hBEEF, lat, rd, b, er, r0, r0d);
        chk("wr_busy_from_k", b, 1'b1);
        chk("wr_latency", lat, 2);
        chk("wr_rdata_unchanged", rd, 16'h0000);
        chk("wr_w0_ready_next", r0, 1'b1);
        access(1'b0, 8'h10, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("rd_beef", rd, 16'hBEEF);
        chk("rd_latency", lat, 2);
        repeat (3) @(negedge Clk);
        chk("rd_hold_idle", rd_w[0], 16'hBEEF);
        access(1'b1, 8'h10, 16'h1111, lat, rd, b, er, r0, r0d);
        chk("rd_hold_write", rd, 16'hBEEF);
        access(1'b0, 8'h10, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("raw_same_addr", rd, 16'h1111);

        access(1'b1, 8'h01, 16'hA001, lat, rd, b, er, r0, r0d);
        access(1'b1, 8'h02, 16'hA002, lat, rd, b, er, r0, r0d);
        access(1'b1, 8'h05, 16'h5555, lat, rd, b, er, r0, r0d);
        access(1'b1, 8'h20, 16'h2020, lat, rd, b, er, r0, r0d);
        access(1'b0, 8'h20, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("w0_ready_after_accept", r0, 1'b1);
        chk("w0_rdata", r0d, 16'h2020);
        chk("w2_rdata_20", rd, 16'h2020);

        @(negedge Clk);
        MemReq = 1'b1;
        MemWrite = 1'b0;
        MemAddr = 8'h01;
        cnt = 0;
        last = 0;
        exp = 16'hA001;
        for (int i = 1; i <= 24; i++) begin
            @(negedge Clk);
            MemWData = 16'(i * 37);
            if (rdy_w[0]) begin
                cnt++;
                chk("stream_data", rd_w[0], exp);
                if (cnt > 1) chk("stream_gap", i - last, 4);
                last = i;
                exp = (exp == 16'hA001) ? 16'hA002 : 16'hA001;
                MemAddr = (MemAddr == 8'h01) ? 8'h02 : 8'h01;
            end
        end
        MemReq = 1'b0;
        chk("stream_count", cnt, 6);
        repeat (4) @(negedge Clk);

        @(negedge Clk);
        MemReq = 1'b1;
        MemWrite = 1'b1;
        MemAddr = 8'h05;
        MemWData = 16'h1234;
        @(negedge Clk);
        MemReq = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy", bsy_w[0], 1'b0);
        chk("abort_ready", rdy_w[0], 1'b0);
        chk("abort_rdata", rd_w[0], 16'h0000);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("abort_no_ready", rdy_w[0], 1'b0);
        end
        access(1'b0, 8'h05, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("abort_keeps_old", rd, 16'h5555);

        @(negedge Clk);
        MemReq = 1'b1;
        MemWrite = 1'b1;
        MemAddr = 8'h06;
        MemWData = 16'h7777;
        @(negedge Clk);
        MemReq = 1'b0;
        repeat (2) @(negedge Clk);
        chk("resp_ready_before_rst", rdy_w[0], 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("resp_rst_ready", rdy_w[0], 1'b0);
        Reset = 1'b0;
        access(1'b0, 8'h06, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("resp_rst_commit", rd, 16'h7777);

        access(1'b1, 8'hC8, 16'hAAAA, lat, rd, b, er, r0, r0d);
        chk("oor_wr_latency", lat, 2);
        chk("oor_wr_err", er, ERR_ON);
        access(1'b0, 8'hC8, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("oor_rd_zero", rd, 16'h0000);
        chk("oor_rd_err", er, ERR_ON);
        access(1'b0, 8'h06, 16'h0000, lat, rd, b, er, r0, r0d);
        chk("inrange_no_err", er, 1'b0);

        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end
endmodule
